// File: rtl/masked_sbox_scheduler_pkg.sv
// Shared types and constants for the masked S-box scheduler.
package masked_sbox_sched_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } sched_state_e;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_SBOX_LAT = 2;

  // Width of a requester ID; at least one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/masked_sbox_scheduler_if.sv
// Requester, PRNG, S-box and response signals of the scheduler.
interface masked_sbox_scheduler_if
  import masked_sbox_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
);
  localparam int ID_W = id_w(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_in0;
  logic [8*NREQ-1:0] req_in1;
  logic              rnd_valid;
  logic              rnd_ready;
  logic [7:0]        rnd_data;
  logic [7:0]        sb_in0;
  logic [7:0]        sb_in1;
  logic [7:0]        sb_r;
  logic              sb_en;
  logic [7:0]        sb_out0;
  logic [7:0]        sb_out1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [7:0]        rsp_out0;
  logic [7:0]        rsp_out1;
  logic              halt;
  logic              idle;

  // Scheduler side
  modport slave (
    input  req_valid, req_in0, req_in1, rnd_valid, rnd_data,
           sb_out0, sb_out1, rsp_ready, halt,
    output req_ready, rnd_ready, sb_in0, sb_in1, sb_r, sb_en,
           rsp_valid, rsp_id, rsp_out0, rsp_out1, idle
  );

  // Environment side (requesters, PRNG, S-box, response sink)
  modport master (
    output req_valid, req_in0, req_in1, rnd_valid, rnd_data,
           sb_out0, sb_out1, rsp_ready, halt,
    input  req_ready, rnd_ready, sb_in0, sb_in1, sb_r, sb_en,
           rsp_valid, rsp_id, rsp_out0, rsp_out1, idle
  );

endinterface

// File: rtl/masked_sbox_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
module rr_arbiter
  import masked_sbox_sched_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] idx;
  logic            found;

  // Scan from the requester after the pointer, wrapping once around
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end
    end
  end

  // Pointer moves to the winner only when the grant is actually taken
  always_comb begin
    ptr_d = advance ? grant_id : ptr_q;
  end

  // Pointer register; resets so that requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= ID_W'(NREQ - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/masked_sbox_scheduler.sv
// Shares one pipelined two-share masked S-box among NREQ byte requesters,
// tracking requester IDs alongside the S-box pipeline.
module masked_sbox_scheduler
  import masked_sbox_sched_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int SBOX_LAT = DEF_SBOX_LAT
) (
  input logic                    clk,
  input logic                    rst_n,
  masked_sbox_scheduler_if.slave bus
);

  localparam int ID_W = id_w(NREQ);

  sched_state_e        state_q, state_d;
  logic                active_q;
  logic [SBOX_LAT-1:0] tag_valid_q, tag_valid_d;
  logic [ID_W-1:0]     tag_id_q [SBOX_LAT];
  logic [ID_W-1:0]     tag_id_d [SBOX_LAT];

  logic                any_valid;
  logic                rsp_valid;
  logic                stall;
  logic                issue_ok;
  logic                issue;
  logic                sb_en;
  logic [NREQ-1:0]     grant;
  logic [ID_W-1:0]     grant_id;
  logic [7:0]          sh0_term [NREQ];
  logic [7:0]          sh1_term [NREQ];
  logic [7:0]          sb_in0_w, sb_in1_w;

  assign any_valid = |tag_valid_q;
  assign rsp_valid = tag_valid_q[SBOX_LAT-1];
  assign stall     = rsp_valid & ~bus.rsp_ready;

  // active_q blocks issue until the first clock after reset release, so
  // grants stay low for the whole time reset is asserted.
  assign issue_ok  = active_q & (state_q == RUN) & ~bus.halt & ~stall & bus.rnd_valid;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.req_valid & {NREQ{issue_ok}}),
    .advance  (issue),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign issue = |grant;
  assign sb_en = ~stall & (issue | any_valid);

  // Per-share AND-OR muxes: share 0 and share 1 never meet in common logic,
  // and a zero grant vector drives zeros onto the S-box inputs.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_share
    assign sh0_term[gi] = {8{grant[gi]}} & bus.req_in0[gi*8 +: 8];
    assign sh1_term[gi] = {8{grant[gi]}} & bus.req_in1[gi*8 +: 8];
  end

  // Share 0 mux reduction
  always_comb begin
    sb_in0_w = '0;
    for (int i = 0; i < NREQ; i++) sb_in0_w = sb_in0_w | sh0_term[i];
  end

  // Share 1 mux reduction
  always_comb begin
    sb_in1_w = '0;
    for (int i = 0; i < NREQ; i++) sb_in1_w = sb_in1_w | sh1_term[i];
  end

  // Tag pipeline shifts in lockstep with the S-box registers
  always_comb begin
    for (int s = 0; s < SBOX_LAT; s++) begin
      tag_valid_d[s] = tag_valid_q[s];
      tag_id_d[s]    = tag_id_q[s];
    end
    if (sb_en) begin
      tag_valid_d[0] = issue;
      tag_id_d[0]    = grant_id;
      for (int s = 1; s < SBOX_LAT; s++) begin
        tag_valid_d[s] = tag_valid_q[s-1];
        tag_id_d[s]    = tag_id_q[s-1];
      end
    end
  end

  // Tag registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_q <= '0;
      for (int s = 0; s < SBOX_LAT; s++) tag_id_q[s] <= '0;
    end else begin
      tag_valid_q <= tag_valid_d;
      for (int s = 0; s < SBOX_LAT; s++) tag_id_q[s] <= tag_id_d[s];
    end
  end

  // Next-state logic for run / drain / halted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (bus.halt)      state_d = DRAIN;
      DRAIN:   if (!bus.halt)     state_d = RUN;
               else if (!any_valid) state_d = HALTED;
      HALTED:  if (!bus.halt)     state_d = RUN;
      default:                    state_d = RUN;
    endcase
  end

  // FSM state and post-reset enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rnd_ready = issue;
  assign bus.sb_in0    = sb_in0_w;
  assign bus.sb_in1    = sb_in1_w;
  assign bus.sb_r      = {8{issue}} & bus.rnd_data;
  assign bus.sb_en     = sb_en;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = tag_id_q[SBOX_LAT-1];
  assign bus.rsp_out0  = bus.sb_out0;
  assign bus.rsp_out1  = bus.sb_out1;
  assign bus.idle      = ~any_valid;

endmodule

// File: tb/tb_masked_sbox_scheduler.sv
// Bench for masked_sbox_scheduler: behavioural S-box environment, a
// transaction-level reference model checked every cycle, and directed tests.
module tb_masked_sbox_scheduler;
  import masked_sbox_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic rst_n;
  initial forever #5 clk = ~clk;

  masked_sbox_scheduler_if #(.NREQ(NREQ)) bus ();

  masked_sbox_scheduler #(.NREQ(NREQ), .SBOX_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // GF(2^8) arithmetic and AES S-box from first principles
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, base, e, s, r;
    inv = 8'h01; base = x; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    s = inv; r = inv;
    for (int i = 0; i < 4; i++) begin
      r = rotl1(r);
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  // Environment: masked S-box with LAT register stages, frozen by sb_en
  logic [7:0] env0 [LAT];
  logic [7:0] env1 [LAT];
  always @(posedge clk) begin
    if (bus.sb_en) begin
      env0[0] <= sbox(bus.sb_in0 ^ bus.sb_in1) ^ bus.sb_r;
      env1[0] <= bus.sb_r;
      for (int s = 1; s < LAT; s++) begin
        env0[s] <= env0[s-1];
        env1[s] <= env1[s-1];
      end
    end
  end
  assign bus.sb_out0 = env0[LAT-1];
  assign bus.sb_out1 = env1[LAT-1];

  // Reference model: in-flight bytes with the number of S-box advances seen
  typedef struct {
    int id;
    int res;
    int age;
  } item_t;

  item_t q[$];
  int    mptr;
  bit    stopped;
  int    e_win, idx, b0, b1, br;
  bit    front_rdy, e_stall, e_issue, e_sben, h_s;
  item_t it_new;

  initial begin : compare
    mptr = NREQ - 1;
    stopped = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        mptr = NREQ - 1;
        stopped = 1'b0;
      end
      front_rdy = (q.size() > 0) && (q[0].age == LAT);
      e_stall   = front_rdy && !bus.rsp_ready;
      e_win = -1;
      for (int k = 1; k <= NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (e_win < 0 && bus.req_valid[idx]) e_win = idx;
      end
      e_issue = rst_n && !stopped && !bus.halt && !e_stall && bus.rnd_valid && (e_win >= 0);
      e_sben  = !e_stall && (e_issue || q.size() > 0);
      b0 = e_issue ? int'(bus.req_in0[e_win*8 +: 8]) : 0;
      b1 = e_issue ? int'(bus.req_in1[e_win*8 +: 8]) : 0;
      br = e_issue ? int'(bus.rnd_data) : 0;
      h_s = bus.halt;

      chk("req_ready", int'(bus.req_ready), e_issue ? (1 << e_win) : 0);
      chk("rnd_ready", int'(bus.rnd_ready), int'(e_issue));
      chk("sb_in0",    int'(bus.sb_in0), b0);
      chk("sb_in1",    int'(bus.sb_in1), b1);
      chk("sb_r",      int'(bus.sb_r), br);
      chk("sb_en",     int'(bus.sb_en), int'(e_sben));
      chk("rsp_valid", int'(bus.rsp_valid), int'(front_rdy));
      chk("idle",      int'(bus.idle), int'(q.size() == 0));
      if (front_rdy) begin
        chk("rsp_id",     int'(bus.rsp_id), q[0].id);
        chk("rsp_result", int'(bus.rsp_out0 ^ bus.rsp_out1), q[0].res);
      end

      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        mptr = NREQ - 1;
        stopped = 1'b0;
      end else begin
        stopped = h_s;
        if (e_issue) mptr = e_win;
        if (e_sben) begin
          if (front_rdy) void'(q.pop_front());
          foreach (q[i]) q[i].age++;
          if (e_issue) begin
            it_new.id  = e_win;
            it_new.res = int'(sbox(8'(b0 ^ b1)));
            it_new.age = 1;
            q.push_back(it_new);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    bus.req_valid = '0;
    bus.rnd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (n) cyc();
  endtask

  int lat;
  bit seen;

  initial begin : driver
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_in0   = '0;
    bus.req_in1   = '0;
    bus.rnd_valid = 1'b0;
    bus.rnd_data  = '0;
    bus.rsp_ready = 1'b1;
    bus.halt      = 1'b0;

    // Pin the S-box model
    chk("model_sbox_66", int'(sbox(8'h66)), 8'h33);
    chk("model_sbox_00", int'(sbox(8'h00)), 8'h63);
    chk("model_sbox_53", int'(sbox(8'h53)), 8'hED);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_idle", int'(bus.idle), 1);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_sb_en", int'(bus.sb_en), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();

    // T1: requester 2 alone
    bus.req_valid = 4'b0100;
    bus.req_in0[23:16] = 8'h3A;
    bus.req_in1[23:16] = 8'h5C;
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = 8'hA5;
    @(negedge clk);
    chk("t1_grant", int'(bus.req_ready), 4);
    chk("t1_rnd_ready", int'(bus.rnd_ready), 1);
    chk("t1_sb_in0", int'(bus.sb_in0), 8'h3A);
    chk("t1_sb_in1", int'(bus.sb_in1), 8'h5C);
    chk("t1_sb_r", int'(bus.sb_r), 8'hA5);
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.rnd_valid = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int it = 0; it < 10 && !seen; it++) begin
      @(negedge clk);
      lat++;
      seen = bus.rsp_valid;
      if (seen) begin
        chk("t1_rsp_id", int'(bus.rsp_id), 2);
        chk("t1_unmasked", int'(bus.rsp_out0 ^ bus.rsp_out1), 8'h33);
      end
      @(posedge clk); #1;
    end
    chk("t1_latency", lat, 2);
    drain(3);

    // T2: all requesters busy, grants rotate from requester 3
    for (int i = 0; i < NREQ; i++) begin
      bus.req_in0[i*8 +: 8] = 8'(8'h11 * (i + 1));
      bus.req_in1[i*8 +: 8] = 8'(8'hC3 ^ i);
    end
    bus.req_valid = 4'hF;
    bus.rnd_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.rnd_data = 8'(k * 37 + 1);
      @(negedge clk);
      chk("t2_grant", int'(bus.req_ready), 1 << ((3 + k) % 4));
      @(posedge clk); #1;
    end
    drain(4);

    // T3: PRNG valid toggles 1,0,1,0
    bus.req_valid = 4'hF;
    bus.rnd_data  = 8'h77;
    for (int k = 0; k < 4; k++) begin
      bus.rnd_valid = (k % 2 == 0);
      @(negedge clk);
      chk("t3_rnd_ready", int'(bus.rnd_ready), (k % 2 == 0) ? 1 : 0);
      if (k == 0) chk("t3_grant0", int'(bus.req_ready), 8);
      if (k == 2) chk("t3_grant2", int'(bus.req_ready), 1);
      if (k % 2 == 1) begin
        chk("t3_idle_sb_r", int'(bus.sb_r), 0);
        chk("t3_idle_sb_in0", int'(bus.sb_in0), 0);
        chk("t3_idle_grant", int'(bus.req_ready), 0);
      end
      @(posedge clk); #1;
    end
    drain(4);

    // T4: fill the pipeline, then hold off the sink for 5 cycles
    bus.req_valid = 4'hF;
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = 8'h3C;
    repeat (2) cyc();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_sb_en", int'(bus.sb_en), 0);
      chk("t4_rsp_valid", int'(bus.rsp_valid), 1);
      chk("t4_no_grant", int'(bus.req_ready), 0);
      @(posedge clk); #1;
    end
    drain(5);

    // T5: halt with two bytes in flight
    bus.req_valid = 4'hF;
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = 8'h96;
    repeat (2) cyc();
    bus.halt = 1'b1;
    seen = 1'b0;
    for (int it = 0; it < 10 && !seen; it++) begin
      @(negedge clk);
      chk("t5_no_grant", int'(bus.req_ready), 0);
      seen = bus.idle;
      @(posedge clk); #1;
    end
    chk("t5_drained", int'(seen), 1);
    @(negedge clk);
    chk("t5_halted", int'(dut.state_q), int'(HALTED));
    @(posedge clk); #1;
    bus.halt = 1'b0;
    @(negedge clk);
    chk("t5_release_cycle", int'(bus.req_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_run", int'(dut.state_q), int'(RUN));
    chk("t5_resume", int'(bus.req_ready != 0), 1);
    @(posedge clk); #1;
    drain(4);

    // T6: reset mid-stream
    bus.req_valid = 4'hF;
    bus.rnd_valid = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rsp_valid", int'(bus.rsp_valid), 0);
    chk("t6_sb_en", int'(bus.sb_en), 0);
    chk("t6_idle", int'(bus.idle), 1);
    chk("t6_no_grant", int'(bus.req_ready), 0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst_n = 1'b1;
    cyc();
    bus.req_valid = 4'hF;
    @(negedge clk);
    chk("t6_first_grant", int'(bus.req_ready), 1);
    @(posedge clk); #1;
    drain(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
